// File: rtl/fft_sram_sequencer_pkg.sv
// Shared types and helpers for the FFT job sequencer.
package fft_sram_sequencer_pkg;

    localparam int unsigned DEF_DATA_W  = 128;
    localparam int unsigned DEF_ADDR_W  = 8;
    localparam int unsigned DEF_TIMEOUT = 65535;

    // Point configuration 7 would mean 2048 points, which the engine cannot run.
    localparam logic [2:0] ILLEGAL_CFG = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_UNLOAD
    } state_e;

    // Four complex samples per SRAM word: 16<<cfg points -> 4<<cfg words.
    function automatic logic [15:0] cfg_to_words(input logic [2:0] cfg);
        return 16'(4) << cfg;
    endfunction

endpackage

// File: rtl/fft_sram_sequencer_if.sv
// Host load/unload valid-ready streams of the FFT job sequencer.
interface fft_sram_sequencer_if #(
    parameter int unsigned DATA_W = 128
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/fft_sram_sequencer_skid.sv
// Two-entry skid FIFO that absorbs SRAM read latency on the unload path.
module fft_skid_fifo #(
    parameter int unsigned DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        count_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [DATA_W-1:0] mem_q [2];
    logic              rd_ptr_q;
    logic              wr_ptr_q;
    logic [1:0]        count_q;
    logic              do_push;
    logic              do_pop;

    assign empty_o = (count_q == 2'd0);
    assign full_o  = (count_q == 2'd2);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Storage, pointers and occupancy; flush discards everything held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/fft_sram_sequencer.sv
// Sequences one FFT job (load, run, unload) and owns the coefficient SRAM muxes.
module fft_sram_sequencer
    import fft_sram_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [2:0]           i_point_config,
    input  logic                 i_abort,
    fft_sram_sequencer_if.slave  host,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_error,
    output logic                 o_fft_working,
    output logic [2:0]           o_fft_point_config,
    input  logic                 i_fft_done,
    input  logic [ADDR_W-1:0]    i_fft_raddr1,
    input  logic [ADDR_W-1:0]    i_fft_raddr2,
    input  logic [ADDR_W-1:0]    i_fft_waddr1,
    input  logic [ADDR_W-1:0]    i_fft_waddr2,
    input  logic [DATA_W-1:0]    i_fft_wdata1,
    input  logic [DATA_W-1:0]    i_fft_wdata2,
    input  logic                 i_fft_we,
    output logic [ADDR_W-1:0]    o_sram_raddr1,
    output logic [ADDR_W-1:0]    o_sram_raddr2,
    output logic [ADDR_W-1:0]    o_sram_waddr1,
    output logic [ADDR_W-1:0]    o_sram_waddr2,
    output logic [DATA_W-1:0]    o_sram_wdata1,
    output logic [DATA_W-1:0]    o_sram_wdata2,
    output logic                 o_sram_we,
    input  logic [DATA_W-1:0]    i_sram_rdata1
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned RUN_W = $clog2(TIMEOUT + 1);

    state_e            state_q;
    logic [2:0]        cfg_q;
    logic [CNT_W-1:0]  load_cnt_q;
    logic [CNT_W-1:0]  rd_cnt_q;
    logic [CNT_W-1:0]  out_cnt_q;
    logic [RUN_W-1:0]  run_cnt_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;
    logic              working_q;
    logic              in_ready_q;
    logic              rd_pend_q;

    logic [CNT_W-1:0]  words;
    logic [CNT_W-1:0]  last_idx;
    logic              in_hs;
    logic              out_hs;
    logic              rd_issue;
    logic              fifo_push;
    logic [2:0]        occ_after_pop;
    logic [1:0]        fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data;

    assign words    = CNT_W'(cfg_to_words(cfg_q));
    assign last_idx = words - CNT_W'(1);
    assign in_hs    = in_ready_q & host.in_valid & ~i_abort;
    assign out_hs   = ~fifo_empty & host.out_ready;

    // Credit counts the word leaving this cycle, so a steady ready stream sees no bubbles.
    assign occ_after_pop = 3'(fifo_count) + 3'(rd_pend_q) - 3'(out_hs);
    assign rd_issue  = (state_q == ST_UNLOAD) & (rd_cnt_q < words) & (occ_after_pop < 3'd2);
    assign fifo_push = rd_pend_q & (~fifo_full | out_hs);

    assign o_busy             = busy_q;
    assign o_done             = done_q;
    assign o_error            = error_q;
    assign o_fft_working      = working_q;
    assign o_fft_point_config = cfg_q;
    assign host.in_ready      = in_ready_q;
    assign host.out_valid     = ~fifo_empty;
    assign host.out_data      = fifo_data;

    fft_skid_fifo #(.DATA_W(DATA_W)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .data_i  (i_sram_rdata1),
        .pop_i   (out_hs),
        .flush_i (i_abort),
        .data_o  (fifo_data),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Job FSM with its counters and registered status outputs; abort overrides all.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cfg_q      <= '0;
            load_cnt_q <= '0;
            rd_cnt_q   <= '0;
            out_cnt_q  <= '0;
            run_cnt_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            working_q  <= 1'b0;
            in_ready_q <= 1'b0;
            rd_pend_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (i_abort) begin
                state_q    <= ST_IDLE;
                busy_q     <= 1'b0;
                working_q  <= 1'b0;
                in_ready_q <= 1'b0;
                rd_pend_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (i_start) begin
                            if (i_point_config == ILLEGAL_CFG) begin
                                error_q <= 1'b1;
                            end else begin
                                error_q    <= 1'b0;
                                cfg_q      <= i_point_config;
                                load_cnt_q <= '0;
                                state_q    <= ST_LOAD;
                                busy_q     <= 1'b1;
                                in_ready_q <= 1'b1;
                            end
                        end
                    end
                    ST_LOAD: begin
                        if (in_hs) begin
                            load_cnt_q <= load_cnt_q + CNT_W'(1);
                            if (load_cnt_q == last_idx) begin
                                state_q    <= ST_RUN;
                                in_ready_q <= 1'b0;
                                working_q  <= 1'b1;
                                run_cnt_q  <= '0;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (i_fft_done) begin
                            state_q   <= ST_UNLOAD;
                            working_q <= 1'b0;
                            rd_cnt_q  <= '0;
                            out_cnt_q <= '0;
                            rd_pend_q <= 1'b0;
                        end else if (run_cnt_q == RUN_W'(TIMEOUT - 1)) begin
                            error_q   <= 1'b1;
                            state_q   <= ST_IDLE;
                            working_q <= 1'b0;
                            busy_q    <= 1'b0;
                        end else begin
                            run_cnt_q <= run_cnt_q + RUN_W'(1);
                        end
                    end
                    ST_UNLOAD: begin
                        rd_pend_q <= rd_issue;
                        if (rd_issue) rd_cnt_q <= rd_cnt_q + CNT_W'(1);
                        if (out_hs) begin
                            out_cnt_q <= out_cnt_q + CNT_W'(1);
                            if (out_cnt_q == last_idx) begin
                                done_q  <= 1'b1;
                                state_q <= ST_IDLE;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    // SRAM ownership mux: host writes in LOAD, engine in RUN, unload reads in UNLOAD.
    always_comb begin
        o_sram_raddr1 = '0;
        o_sram_raddr2 = '0;
        o_sram_waddr1 = '0;
        o_sram_waddr2 = '0;
        o_sram_wdata1 = '0;
        o_sram_wdata2 = '0;
        o_sram_we     = 1'b0;
        case (state_q)
            ST_LOAD: begin
                o_sram_waddr1 = load_cnt_q[ADDR_W-1:0];
                o_sram_wdata1 = host.in_data;
                o_sram_we     = in_hs;
            end
            ST_RUN: begin
                o_sram_raddr1 = i_fft_raddr1;
                o_sram_raddr2 = i_fft_raddr2;
                o_sram_waddr1 = i_fft_waddr1;
                o_sram_waddr2 = i_fft_waddr2;
                o_sram_wdata1 = i_fft_wdata1;
                o_sram_wdata2 = i_fft_wdata2;
                o_sram_we     = i_fft_we;
            end
            ST_UNLOAD: begin
                o_sram_raddr1 = rd_cnt_q[ADDR_W-1:0];
            end
            default: ;
        endcase
    end

endmodule
